// File: rtl/fifo1.sv
// rtl/fifo1.sv - single-clock first-word-fall-through FIFO with extra-wrap-bit pointers
// Optional FIFO1_POWER_GATE_EN: power_en=0 freezes all reads and writes.
module fifo1 #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             power_en,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic             gate_open;
  logic             wr_en;
  logic             rd_en;

`ifdef FIFO1_POWER_GATE_EN
  assign gate_open = power_en;
`else
  logic unused_power_en;
  assign unused_power_en = power_en;
  assign gate_open       = 1'b1;
`endif

  // Equal pointers mean empty; same slot one lap apart means full.
  assign rempty = (wptr == rptr);
  assign wfull  = (wptr[ASIZE] != rptr[ASIZE]) &&
                  (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);

  assign wr_en = winc && !wfull  && gate_open;
  assign rd_en = rinc && !rempty && gate_open;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  // Storage is never cleared; reset only makes old words unreachable.
  always_ff @(posedge wclk) begin
    if (wrst_n && wr_en) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  assign rdata = rempty ? '0 : mem[rptr[ASIZE-1:0]];

endmodule

// File: tb/tb_fifo1.sv
// tb/tb_fifo1.sv - self-checking bench for fifo1 (vector table, directed sequences, random vs queue model)
module tb_fifo1;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic             wclk = 1'b0;
  logic             wrst_n = 1'b0;
  logic             power_en = 1'b1;
  logic             winc = 1'b0;
  logic [DSIZE-1:0] wdata = '0;
  logic             rinc = 1'b0;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;

  int errors = 0;
  int checks = 0;

  logic [DSIZE-1:0] mq [$];

  fifo1 #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .power_en (power_en),
    .winc     (winc),
    .wdata    (wdata),
    .rinc     (rinc),
    .rdata    (rdata),
    .wfull    (wfull),
    .rempty   (rempty)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       rst_n;
    logic       wi;
    logic       ri;
    logic [7:0] wd;
    logic [7:0] er;
    logic       ee;
    logic       ef;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic gate(input logic pwr);
`ifdef FIFO1_POWER_GATE_EN
    return pwr;
`else
    return 1'b1;
`endif
  endfunction

  // Reference: a queue; occupancy decides what is accepted this edge.
  task automatic model_step(input logic rst, input logic pwr, input logic wi, input logic ri,
                            input logic [7:0] wd);
    int n;
    if (!rst) begin
      mq.delete();
    end else if (gate(pwr)) begin
      n = mq.size();
      if (ri && n != 0) void'(mq.pop_front());
      if (wi && n != DEPTH) mq.push_back(wd);
    end
  endtask

  task automatic tick(input logic rst, input logic pwr, input logic wi, input logic ri,
                      input logic [7:0] wd);
    wrst_n   = rst;
    power_en = pwr;
    winc     = wi;
    rinc     = ri;
    wdata    = wd;
    @(posedge wclk);
    #1;
    model_step(rst, pwr, wi, ri, wd);
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] er;
    er = (mq.size() != 0) ? mq[0] : 8'h00;
    chk({tag, ".rdata"},  {24'b0, rdata}, {24'b0, er});
    chk({tag, ".rempty"}, {31'b0, rempty}, {31'b0, mq.size() == 0});
    chk({tag, ".wfull"},  {31'b0, wfull},  {31'b0, mq.size() == DEPTH});
  endtask

  initial begin
    logic [7:0] snap_r;
    logic       wi, ri, pw, rs;

    // Ordering and underflow as fixed vectors.
    vt.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0});
    for (int i = 0; i < 6; i++)
      vt.push_back('{1'b1, 1'b1, 1'b0, 8'hA0 + 8'(i), 8'hA0, 1'b0, 1'b0});
    for (int i = 1; i < 6; i++)
      vt.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'hA0 + 8'(i), 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++)
      vt.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1'b0, 8'h55, 8'h55, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0});

    for (int i = 0; i < vt.size(); i++) begin
      tick(vt[i].rst_n, 1'b1, vt[i].wi, vt[i].ri, vt[i].wd);
      chk($sformatf("vec%0d.rdata", i), {24'b0, rdata}, {24'b0, vt[i].er});
      chk($sformatf("vec%0d.rempty", i), {31'b0, rempty}, {31'b0, vt[i].ee});
      chk($sformatf("vec%0d.wfull", i), {31'b0, wfull}, {31'b0, vt[i].ef});
    end

    // Fill and overflow.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 8'hA0 + 8'(i));
      if (i >= 15) chk($sformatf("fill%0d.wfull", i), {31'b0, wfull}, 32'd1);
      else         chk($sformatf("fill%0d.wfull", i), {31'b0, wfull}, 32'd0);
    end
    chk("fill.head", {24'b0, rdata}, 32'hA0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ovf_pop%0d.rdata", i), {24'b0, rdata}, 32'hA0 + i);
      tick(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      chk($sformatf("ovf_pop%0d.wfull", i), {31'b0, wfull}, 32'd0);
    end
    chk("ovf.head", {24'b0, rdata}, 32'hA6);

    // Simultaneous push/pop at 15 words and at full.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 8'h10 + 8'(i));
    tick(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
    chk("sim15.head", {24'b0, rdata}, 32'h11);
    chk("sim15.wfull", {31'b0, wfull}, 32'd0);
    chk("sim15.count", mq.size(), 32'd15);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 8'h20);
    chk("sim16.wfull", {31'b0, wfull}, 32'd1);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 8'h88);
    chk("simfull.wfull", {31'b0, wfull}, 32'd0);
    chk("simfull.head", {24'b0, rdata}, 32'h12);
    for (int i = 0; i < 15; i++) begin
      check_model($sformatf("simdrain%0d", i));
      chk($sformatf("simdrain%0d.not88", i), {31'b0, rdata == 8'h88}, 32'd0);
      tick(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    end
    chk("simdrain.rempty", {31'b0, rempty}, 32'd1);

    // Power gate with both requests held.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 8'hC0 + 8'(i));
    snap_r = 8'hC0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b1, 8'hEE);
      check_model($sformatf("pgate%0d", i));
`ifdef FIFO1_POWER_GATE_EN
      chk($sformatf("pgate%0d.hold", i), {24'b0, rdata}, {24'b0, snap_r});
`endif
    end
    while (mq.size() != 0) begin
      check_model("pdrain");
      tick(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    end
    check_model("pdrain.end");

    // Reset with 8 words stored.
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 8'h60 + 8'(i));
    tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h99);
    chk("rst.rempty", {31'b0, rempty}, 32'd1);
    chk("rst.wfull", {31'b0, wfull}, 32'd0);
    chk("rst.rdata", {24'b0, rdata}, 32'h00);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 8'h3C);
    chk("rst.new", {24'b0, rdata}, 32'h3C);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("rst.newpop", {31'b0, rempty}, 32'd1);

    // Random traffic in phases biased toward filling or draining.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 200) % 2 == 0) ? 75 : 25;
      wi = ($urandom_range(99) < bias);
      ri = ($urandom_range(99) < 100 - bias);
      pw = ($urandom_range(9) != 0);
      rs = ($urandom_range(499) != 0);
      tick(rs, pw, wi, ri, 8'($urandom));
      check_model($sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d.excl", i), {31'b0, rempty && wfull}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
